// File: rtl/i2c_bus_bridge.sv
// I2C target front end for the LED driver: decodes the I2C link and turns
// pointer-protocol transfers into single-cycle register-bus writes and reads.
`timescale 1ns/1ps
module i2c_bus_bridge #(
  parameter logic [6:0] DEV_ADDR  = 7'h62,
  parameter int         ADDR_BITS = 4,
  parameter int         DATA_BITS = 8,
  parameter int         REG_COUNT = 13
) (
  input  logic                 clk_400K,
  input  logic                 reset_n,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic [DATA_BITS-1:0] bus_wdata,
  input  logic [DATA_BITS-1:0] bus_rdata,
  output logic                 bus_w_en,
  output logic                 bus_r_en,
  output logic                 busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WDATA, DATA_ACK, RD_FETCH, RDATA, RACK, IGNORE
  } stateT;

  localparam logic [ADDR_BITS-1:0] LAST_PTR = ADDR_BITS'(REG_COUNT - 1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  logic sclMeta_q, sclSync_q, sclHist_q;
  logic sdaMeta_q, sdaSync_q, sdaHist_q;

  stateT                state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bitCnt_q, bitCnt_d;
  logic                 ackBit_q, ackBit_d;
  logic                 sdaOe_q, sdaOe_d;
  logic [ADDR_BITS-1:0] busAddr_q, busAddr_d;
  logic [DATA_BITS-1:0] busWdata_q, busWdata_d;
  logic                 wEn_q, wEn_d;
  logic                 rEn_q, rEn_d;
  logic                 busy_q, busy_d;

  logic                 sclRise, sclFall, startDet, stopDet;
  logic [ADDR_BITS-1:0] nextPtr;

  // Synchronizers carry no reset so a reset cannot fabricate a START or STOP.
  always_ff @(posedge clk_400K) begin
    sclMeta_q <= scl_in;
    sclSync_q <= sclMeta_q;
    sclHist_q <= sclSync_q;
    sdaMeta_q <= sda_in;
    sdaSync_q <= sdaMeta_q;
    sdaHist_q <= sdaSync_q;
  end

  assign sclRise  = sclSync_q & ~sclHist_q;
  assign sclFall  = ~sclSync_q & sclHist_q;
  assign startDet = sclSync_q & sclHist_q & ~sdaSync_q & sdaHist_q;
  assign stopDet  = sclSync_q & sclHist_q & sdaSync_q & ~sdaHist_q;
  assign nextPtr  = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_ONE;

  always_ff @(posedge clk_400K) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      shift_q    <= '0;
      bitCnt_q   <= '0;
      ackBit_q   <= 1'b1;
      sdaOe_q    <= 1'b0;
      busAddr_q  <= '0;
      busWdata_q <= '0;
      wEn_q      <= 1'b0;
      rEn_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      shift_q    <= shift_d;
      bitCnt_q   <= bitCnt_d;
      ackBit_q   <= ackBit_d;
      sdaOe_q    <= sdaOe_d;
      busAddr_q  <= busAddr_d;
      busWdata_q <= busWdata_d;
      wEn_q      <= wEn_d;
      rEn_q      <= rEn_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    shift_d    = shift_q;
    bitCnt_d   = bitCnt_q;
    ackBit_d   = ackBit_q;
    sdaOe_d    = sdaOe_q;
    busAddr_d  = busAddr_q;
    busWdata_d = busWdata_q;
    wEn_d      = 1'b0;
    rEn_d      = 1'b0;
    busy_d     = busy_q;

    // The pointer advances on the clock after each write strobe.
    if (wEn_q) ptr_d = nextPtr;

    if (stopDet) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sdaOe_d  = 1'b0;
      bitCnt_d = '0;
    end else if (startDet) begin
      state_d  = ADDR;
      bitCnt_d = '0;
      sdaOe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (sclRise && bitCnt_q < 4'd8) begin
            shift_d  = {shift_q[DATA_BITS-2:0], sdaSync_q};
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall && bitCnt_q == 4'd8) begin
            bitCnt_d = '0;
            case (state_q)
              ADDR: begin
                if (shift_q[DATA_BITS-1:1] == DEV_ADDR) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  sdaOe_d = 1'b1;
                end else begin
                  state_d = IGNORE;
                end
              end
              PTR: begin
                ptr_d   = shift_q[ADDR_BITS-1:0];
                sdaOe_d = 1'b1;
                state_d = DATA_ACK;
              end
              default: begin
                busAddr_d  = ptr_q;
                busWdata_d = shift_q;
                wEn_d      = 1'b1;
                sdaOe_d    = 1'b1;
                state_d    = DATA_ACK;
              end
            endcase
          end
        end
        ADDR_ACK: begin
          if (sclFall) begin
            if (shift_q[0]) begin
              // ACK stays driven until the first read bit replaces it.
              state_d   = RD_FETCH;
              rEn_d     = 1'b1;
              busAddr_d = ptr_q;
            end else begin
              sdaOe_d = 1'b0;
              state_d = PTR;
            end
          end
        end
        DATA_ACK: begin
          if (sclFall) begin
            sdaOe_d = 1'b0;
            state_d = WDATA;
          end
        end
        RD_FETCH: begin
          shift_d  = bus_rdata;
          sdaOe_d  = ~bus_rdata[DATA_BITS-1];
          ptr_d    = nextPtr;
          bitCnt_d = 4'd1;
          state_d  = RDATA;
        end
        RDATA: begin
          if (sclFall) begin
            if (bitCnt_q < 4'd8) begin
              sdaOe_d  = ~shift_q[DATA_BITS-2];
              shift_d  = {shift_q[DATA_BITS-2:0], 1'b0};
              bitCnt_d = bitCnt_q + 4'd1;
            end else begin
              sdaOe_d = 1'b0;
              state_d = RACK;
            end
          end
        end
        RACK: begin
          if (sclRise) ackBit_d = sdaSync_q;
          if (sclFall) begin
            if (!ackBit_q) begin
              state_d   = RD_FETCH;
              rEn_d     = 1'b1;
              busAddr_d = ptr_q;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe    = sdaOe_q;
  assign bus_addr  = busAddr_q;
  assign bus_wdata = busWdata_q;
  assign bus_w_en  = wEn_q;
  assign bus_r_en  = rEn_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_bus_bridge.sv
// Directed bench for i2c_bus_bridge: a bit-banged I2C master, a bus monitor
// and a small register file feeding read data.
`timescale 1ns/1ps
module tb_i2c_bus_bridge;

  localparam int Q = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sclM = 1'b1;
  logic       sdaM = 1'b1;
  logic       sda_oe, bus_w_en, bus_r_en, busy;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  logic       sdaLine;
  logic [7:0] regFile [16];

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] wQ[$];
  logic [3:0]  rQ[$];
  int oeCnt = 0, busyCnt = 0, overlapCnt = 0, longCnt = 0;
  logic prevW = 1'b0, prevR = 1'b0;

  always #5 clk = ~clk;

  assign sdaLine   = sdaM & ~sda_oe;
  assign bus_rdata = regFile[bus_addr];

  i2c_bus_bridge dut (
    .clk_400K (clk),
    .reset_n  (reset_n),
    .scl_in   (sclM),
    .sda_in   (sdaLine),
    .sda_oe   (sda_oe),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_w_en (bus_w_en),
    .bus_r_en (bus_r_en),
    .busy     (busy)
  );

  // Record every strobe and count protocol violations, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_w_en) wQ.push_back({bus_addr, bus_wdata});
    if (bus_r_en) rQ.push_back(bus_addr);
    if (sda_oe) oeCnt++;
    if (busy) busyCnt++;
    if (bus_w_en && bus_r_en) overlapCnt++;
    if ((bus_w_en && prevW) || (bus_r_en && prevR)) longCnt++;
    prevW = bus_w_en;
    prevR = bus_r_en;
  end

  // A hung handshake must still end in a report.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic scl, input logic sda, input int cycles);
    sclM = scl;
    sdaM = sda;
    repeat (cycles) @(negedge clk);
  endtask

  function automatic logic [31:0] wAt(input int i);
    return (wQ.size() > i) ? {20'd0, wQ[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rAt(input int i);
    return (rQ.size() > i) ? {28'd0, rQ[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic i2cStart();
    applyStimulus(sclM, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, H);
    applyStimulus(1'b1, 1'b0, H);
    applyStimulus(1'b0, 1'b0, Q);
  endtask

  task automatic i2cStop();
    applyStimulus(1'b0, 1'b0, Q);
    applyStimulus(1'b1, 1'b0, H);
    applyStimulus(1'b1, 1'b1, H);
  endtask

  task automatic writeBit(input logic b);
    applyStimulus(1'b0, b, Q);
    applyStimulus(1'b1, b, H);
    applyStimulus(1'b0, b, Q);
  endtask

  task automatic readBit(output logic b);
    applyStimulus(1'b0, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    b = sdaLine;
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b0, 1'b1, Q);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(b[i]);
    readBit(ack);
  endtask

  task automatic recvByte(input logic ackBit, output logic [7:0] b);
    logic bitVal;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      readBit(bitVal);
      b = {b[6:0], bitVal};
    end
    writeBit(ackBit);
  endtask

  task automatic checkIdleOutputs(input string pfx);
    checkOutput({pfx, " sda_oe"}, 32'(sda_oe), 0);
    checkOutput({pfx, " bus_addr"}, 32'(bus_addr), 0);
    checkOutput({pfx, " bus_wdata"}, 32'(bus_wdata), 0);
    checkOutput({pfx, " bus_w_en"}, 32'(bus_w_en), 0);
    checkOutput({pfx, " bus_r_en"}, 32'(bus_r_en), 0);
    checkOutput({pfx, " busy"}, 32'(busy), 0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         wBase, rBase, oeBase, busyBase;
    logic [7:0] partial;

    for (int i = 0; i < 16; i++) regFile[i] = 8'(8'h10 + i);
    regFile[0] = 8'h5A;
    regFile[4] = 8'hC0;
    regFile[5] = 8'h80;

    // Power-on reset.
    applyStimulus(1'b1, 1'b1, 4);
    checkIdleOutputs("reset");
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 4);

    // Single write: addr 2 <= 0x40.
    wBase = wQ.size();
    i2cStart();
    sendByte(8'hC4, ack); checkOutput("wr addr ack", 32'(ack), 0);
    sendByte(8'h02, ack); checkOutput("wr ptr ack", 32'(ack), 0);
    sendByte(8'h40, ack); checkOutput("wr data ack", 32'(ack), 0);
    checkOutput("wr busy", 32'(busy), 1);
    i2cStop();
    checkOutput("wr busy after stop", 32'(busy), 0);
    checkOutput("wr count", 32'(wQ.size() - wBase), 1);
    checkOutput("wr strobe", wAt(wBase), 32'h240);

    // Burst write wrapping from 12 to 0.
    wBase = wQ.size();
    i2cStart();
    sendByte(8'hC4, ack); checkOutput("burst addr ack", 32'(ack), 0);
    sendByte(8'h0B, ack); checkOutput("burst ptr ack", 32'(ack), 0);
    sendByte(8'h11, ack); checkOutput("burst d0 ack", 32'(ack), 0);
    sendByte(8'h22, ack); checkOutput("burst d1 ack", 32'(ack), 0);
    sendByte(8'h33, ack); checkOutput("burst d2 ack", 32'(ack), 0);
    i2cStop();
    checkOutput("burst count", 32'(wQ.size() - wBase), 3);
    checkOutput("burst w0", wAt(wBase), 32'hB11);
    checkOutput("burst w1", wAt(wBase + 1), 32'hC22);
    checkOutput("burst w2 wrap", wAt(wBase + 2), 32'h033);

    // Random read via repeated START.
    rBase = rQ.size();
    wBase = wQ.size();
    i2cStart();
    sendByte(8'hC4, ack); checkOutput("rd wr-addr ack", 32'(ack), 0);
    sendByte(8'h04, ack); checkOutput("rd ptr ack", 32'(ack), 0);
    i2cStart();
    sendByte(8'hC5, ack); checkOutput("rd addr ack", 32'(ack), 0);
    recvByte(1'b0, rd); checkOutput("rd byte0", 32'(rd), 32'hC0);
    recvByte(1'b1, rd); checkOutput("rd byte1", 32'(rd), 32'h80);
    applyStimulus(1'b0, 1'b0, Q);
    checkOutput("rd released after nack", 32'(sda_oe), 0);
    i2cStop();
    checkOutput("rd count", 32'(rQ.size() - rBase), 2);
    checkOutput("rd strobe0 addr", rAt(rBase), 4);
    checkOutput("rd strobe1 addr", rAt(rBase + 1), 5);
    checkOutput("rd no writes", 32'(wQ.size() - wBase), 0);

    // Foreign address is ignored entirely.
    wBase = wQ.size(); rBase = rQ.size();
    oeBase = oeCnt; busyBase = busyCnt;
    i2cStart();
    sendByte(8'hA0, ack); checkOutput("miss addr nack", 32'(ack), 1);
    sendByte(8'hFF, ack); checkOutput("miss data nack", 32'(ack), 1);
    i2cStop();
    checkOutput("miss sda_oe cycles", 32'(oeCnt - oeBase), 0);
    checkOutput("miss busy cycles", 32'(busyCnt - busyBase), 0);
    checkOutput("miss strobes", 32'((wQ.size() - wBase) + (rQ.size() - rBase)), 0);

    // STOP after 5 data bits discards the partial byte.
    wBase = wQ.size();
    partial = 8'hE7;
    i2cStart();
    sendByte(8'hC4, ack); checkOutput("abort addr ack", 32'(ack), 0);
    sendByte(8'h03, ack); checkOutput("abort ptr ack", 32'(ack), 0);
    for (int i = 7; i >= 3; i--) writeBit(partial[i]);
    i2cStop();
    checkOutput("abort no write", 32'(wQ.size() - wBase), 0);
    checkOutput("abort busy", 32'(busy), 0);
    i2cStart();
    sendByte(8'hC4, ack); checkOutput("post-abort addr ack", 32'(ack), 0);
    sendByte(8'h07, ack); checkOutput("post-abort ptr ack", 32'(ack), 0);
    sendByte(8'h9A, ack); checkOutput("post-abort data ack", 32'(ack), 0);
    i2cStop();
    checkOutput("post-abort write", wAt(wBase), 32'h79A);

    // Reset while the bridge is driving an ACK.
    i2cStart();
    for (int i = 7; i >= 0; i--) writeBit(partial[i] ^ partial[i] ^ ((8'hC4 >> i) & 1'b1));
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("pre-reset ack driven", 32'(sda_oe), 1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleOutputs("mid reset");
    reset_n = 1'b1;
    i2cStop();
    rBase = rQ.size();
    i2cStart();
    sendByte(8'hC5, ack); checkOutput("post-reset addr ack", 32'(ack), 0);
    recvByte(1'b1, rd); checkOutput("post-reset read", 32'(rd), 32'h5A);
    i2cStop();
    checkOutput("post-reset ptr", rAt(rBase), 0);

    checkOutput("strobe overlap", 32'(overlapCnt), 0);
    checkOutput("strobe long pulse", 32'(longCnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_bus_bridge.md
Name: i2c_bus_bridge

Overview:
- I2C target front end for the LED driver. It decodes an external I2C link and issues single-cycle register writes and reads on the controller's register bus (addr, data, w_en, r_en).
- Sits directly upstream of led_controller, in the clk_400K domain. The top level ties its bus outputs to bus_if.
- Implements the pointer protocol: first byte after a write address sets the register pointer. Later bytes are written or read at that pointer, which auto-increments.

Parameters:
- DEV_ADDR, 7'h62, 7-bit I2C target address.
- ADDR_BITS, 4, register pointer / bus address width.
- DATA_BITS, 8, bus data width; must be 8.
- REG_COUNT, 13, number of registers; pointer wraps REG_COUNT-1 -> 0.

Ports:
- clk_400K  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- scl_in  in  1  raw I2C SCL (asynchronous).
- sda_in  in  1  raw I2C SDA (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- bus_addr  out  ADDR_BITS  register address presented to led_controller.
- bus_wdata  out  DATA_BITS  write data; top level drives bus data only while bus_w_en=1.
- bus_rdata  in  DATA_BITS  read data from bus, valid while bus_r_en=1.
- bus_w_en  out  1  one-cycle write strobe.
- bus_r_en  out  1  one-cycle read strobe.
- busy  out  1  high from an address-matched START until STOP.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, ptr=0.
  - sda_oe=0, bus_addr=0, bus_wdata=0, bus_w_en=0, bus_r_en=0, busy=0.
  - Reset mid-transfer aborts silently; no partial bus write is issued.
- Input conditioning:
  - scl_in/sda_in pass through a 2-flop synchronizer plus one history flop.
  - Edge/START/STOP detect latency is 3 clocks.
  - SCL high and low phases must each be >= 4 clocks (SCL <= 50 kHz).
- Event decode:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Data bits are sampled on the detected SCL rising edge.
  - sda_oe changes only on the cycle after a detected SCL falling edge.
- STOP in any state: goes to IDLE, busy=0, sda_oe=0.
- START in any state, including repeated START: goes to ADDR, bit counter cleared, ptr retained.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first (7-bit address + R/W).
    - On match: go to ADDR_ACK and set busy=1.
    - On mismatch: go to IGNORE, sda_oe stays 0 until STOP/START.
  - ADDR_ACK: sda_oe=1 from the 8th SCL fall to the 9th SCL fall.
    - R/W=0: go to PTR.
    - R/W=1: go to RD_FETCH.
  - PTR: receive 8 bits; ptr <= byte[ADDR_BITS-1:0].
    - If byte >= REG_COUNT, ptr is still loaded and later accesses wrap.
    - ACK as in ADDR_ACK, then go to WDATA.
  - WDATA: receive 8 bits, then ACK.
    - On the cycle after the 8th SCL fall: bus_addr=ptr, bus_wdata=byte, bus_w_en=1 for exactly 1 clock.
    - Next clock: ptr <= (ptr==REG_COUNT-1) ? 0 : ptr+1.
    - Stay in WDATA for further bytes.
  - RD_FETCH: bus_addr=ptr, bus_r_en=1 for exactly 1 clock.
    - bus_rdata is captured into the shift register on that edge.
    - ptr increments and wraps as above.
    - sda_oe = ~MSB. Go to RDATA.
  - RDATA: on each SCL fall, shift out the next bit (sda_oe = ~bit).
    - After the 8th SCL fall, release SDA and go to RACK.
  - RACK: sample SDA at the 9th SCL rise.
    - 0 (ACK): go to RD_FETCH on the 9th SCL fall.
    - 1 (NACK): go to IGNORE.
- Strobes:
  - bus_w_en and bus_r_en are never high in the same cycle.
  - Neither is ever high for more than 1 clock.
  - bus_addr holds its last value between strobes.
- START or STOP arriving mid-byte discards the partial byte; no bus strobe is issued.

Test Plan:
- Reset: reset_n=0 for 2 clocks during traffic -> all outputs 0, ptr=0; next transfer decodes from IDLE.
- Single write: START, 0xC4 (0x62,W), ptr 0x02, data 0x40, STOP -> ACK on all 3 bytes; one bus_w_en with bus_addr=2, bus_wdata=0x40; busy falls after STOP.
- Burst write with wrap: ptr 0x0B, data 0x11, 0x22, 0x33 -> writes addr 11=0x11, addr 12=0x22, addr 0=0x33; exactly 3 w_en pulses.
- Random read: write ptr 0x04, repeated START, 0xC5, master ACK then NACK -> r_en at addr 4 then 5; SDA bits match bus_rdata (e.g. 0xC0, 0x80); released after NACK.
- Address mismatch: START, 0xA0, data 0xFF, STOP -> sda_oe never 1, no strobes, busy=0.
- Abort: STOP after 5 bits of a data byte -> no bus_w_en, state IDLE; next valid write works.
